// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline stall/flush scheduler with memory-wait watchdog
// Optional feature macro: PIPE_PERF_CNT_EN (stall-cycle and redirect counters).
module pipeline_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stall_req,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              br_taken_i,
  input  logic [31:0]       br_target_i,
  output logic [4:0]        stall_o,
  output logic [4:0]        flush_o,
  output logic              pc_redirect_o,
  output logic [31:0]       pc_target_o,
  output logic              mem_abort_o,
  output logic [PERF_W-1:0] stall_cycles_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } state_t;

  localparam logic [4:0] STALL_MEM = 5'b01111;
  localparam logic [4:0] STALL_LU  = 5'b00011;
  localparam logic [4:0] FLUSH_BR  = 5'b00011;
  localparam logic [4:0] FLUSH_MEM = 5'b01000;

  state_t           state;
  logic [CNT_W-1:0] wdog;
  logic             mem_stall;

  // Memory wait state and watchdog; the watchdog is cleared whenever MEM_WAIT is left,
  // so it can never count past TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req && !mem_ack) begin
            state <= MEM_WAIT;
            wdog  <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state <= IDLE;
            wdog  <= '0;
          end else if (wdog == CNT_W'(TIMEOUT)) begin
            state <= ABORT;
            wdog  <= '0;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        ABORT: begin
          state <= IDLE;
          wdog  <= '0;
        end
        default: begin
          state <= IDLE;
          wdog  <= '0;
        end
      endcase
    end
  end

  // Merge hazards with priority memory stall > branch redirect > load-use stall.
  // Outputs are forced low while reset is asserted so they drop asynchronously.
  always_comb begin
    mem_stall     = 1'b0;
    stall_o       = '0;
    flush_o       = '0;
    pc_redirect_o = 1'b0;
    pc_target_o   = '0;
    mem_abort_o   = 1'b0;
    if (rst) begin
      case (state)
        IDLE:     mem_stall = mem_req && !mem_ack;
        MEM_WAIT: mem_stall = !mem_ack;
        default:  mem_stall = 1'b0;
      endcase
      if (state == ABORT) begin
        mem_abort_o = 1'b1;
        flush_o     = FLUSH_MEM;
      end
      if (mem_stall) begin
        stall_o = STALL_MEM;
      end else if (br_taken_i) begin
        // The instruction raising a load-use hazard is flushed, so its stall is moot.
        pc_redirect_o = 1'b1;
        pc_target_o   = br_target_i;
        flush_o       = flush_o | FLUSH_BR;
      end else if (id_stall_req && state != ABORT) begin
        stall_o = STALL_LU;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  // Free-running performance counters, wrapping naturally at 2^PERF_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o != 5'b0) stall_cnt <= stall_cnt + PERF_W'(1);
      if (pc_redirect_o)   flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

  assign stall_cycles_o = stall_cnt;
  assign flush_cnt_o    = flush_cnt;
`else
  assign stall_cycles_o = '0;
  assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl (TIMEOUT=4)
module tb_pipeline_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_stall_req = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ack = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic [4:0]  stall_o, flush_o;
  logic        pc_redirect_o, mem_abort_o;
  logic [31:0] pc_target_o, stall_cycles_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.TIMEOUT(TMO), .CNT_W(8), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .id_stall_req(id_stall_req), .mem_req(mem_req),
    .mem_ack(mem_ack), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .stall_o(stall_o), .flush_o(flush_o), .pc_redirect_o(pc_redirect_o),
    .pc_target_o(pc_target_o), .mem_abort_o(mem_abort_o),
    .stall_cycles_o(stall_cycles_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Model: an access is "outstanding" from the cycle after an unacked request;
  // it times out when it has waited TMO cycles beyond that start without an ack,
  // and the abort lands in the following cycle.
  int          cyc = 0;
  bit          outstanding = 1'b0;
  int          start_cyc = 0;
  int          abort_cyc = -1;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;

  logic [4:0]  e_stall, e_flush;
  logic        e_redir, e_abort, e_hold;
  logic [31:0] e_target;

  always_comb begin
    e_stall = '0; e_flush = '0; e_redir = 1'b0; e_abort = 1'b0; e_hold = 1'b0; e_target = '0;
    if (rst) begin
      e_abort = (abort_cyc == cyc);
      if (e_abort)          e_hold = 1'b0;
      else if (outstanding) e_hold = !mem_ack;
      else                  e_hold = mem_req && !mem_ack;
      e_redir  = !e_hold && br_taken_i;
      e_target = e_redir ? br_target_i : 32'h0;
      e_flush  = (e_abort ? 5'b01000 : 5'b0) | (e_redir ? 5'b00011 : 5'b0);
      if (e_hold)                             e_stall = 5'b01111;
      else if (!e_abort && !e_redir && id_stall_req) e_stall = 5'b00011;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= 1'b0;
      abort_cyc   <= -1;
      m_stall_cnt <= '0;
      m_flush_cnt <= '0;
    end else begin
      cyc <= cyc + 1;
      if (e_stall != 5'b0) m_stall_cnt <= m_stall_cnt + 32'd1;
      if (e_redir)         m_flush_cnt <= m_flush_cnt + 32'd1;
      if (abort_cyc == cyc) begin
        abort_cyc <= -1;
      end else if (outstanding) begin
        if (mem_ack) outstanding <= 1'b0;
        else if (cyc - start_cyc == TMO) begin
          outstanding <= 1'b0;
          abort_cyc   <= cyc + 1;
        end
      end else if (mem_req && !mem_ack) begin
        outstanding <= 1'b1;
        start_cyc   <= cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("stall_o", {27'b0, stall_o}, {27'b0, e_stall});
    chk("flush_o", {27'b0, flush_o}, {27'b0, e_flush});
    chk("pc_redirect_o", {31'b0, pc_redirect_o}, {31'b0, e_redir});
    chk("pc_target_o", pc_target_o, e_target);
    chk("mem_abort_o", {31'b0, mem_abort_o}, {31'b0, e_abort});
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cycles_o", stall_cycles_o, m_stall_cnt);
    chk("flush_cnt_o", flush_cnt_o, m_flush_cnt);
`else
    chk("stall_cycles_o", stall_cycles_o, 32'h0);
    chk("flush_cnt_o", flush_cnt_o, 32'h0);
`endif
  end

  // Apply one cycle of inputs shortly after the rising edge.
  task automatic step(input logic ld, input logic req, input logic ack,
                      input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    id_stall_req = ld; mem_req = req; mem_ack = ack; br_taken_i = br; br_target_i = tgt;
    #2;
  endtask

  initial begin
    #3;
    chk("reset stall", {27'b0, stall_o}, 32'h0);
    chk("reset abort", {31'b0, mem_abort_o}, 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);

    // Load-use stall alone.
    step(1, 0, 0, 0, 0);
    chk("lu stall", {27'b0, stall_o}, 32'h3);
    chk("lu flush", {27'b0, flush_o}, 32'h0);
    chk("lu redirect", {31'b0, pc_redirect_o}, 32'h0);

    // Branch overrides load-use.
    step(1, 0, 0, 1, 32'h0000_0100);
    chk("br flush", {27'b0, flush_o}, 32'h3);
    chk("br redirect", {31'b0, pc_redirect_o}, 32'h1);
    chk("br target", pc_target_o, 32'h100);
    chk("br stall", {27'b0, stall_o}, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("idle target", pc_target_o, 32'h0);
`ifdef PIPE_PERF_CNT_EN
    chk("flush_cnt after br", flush_cnt_o, 32'h1);
    chk("stall_cycles after lu", stall_cycles_o, 32'h1);
`endif

    // Memory wait released on the fourth cycle.
    step(0, 1, 0, 0, 0);
    chk("mw c1 stall", {27'b0, stall_o}, 32'hF);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("mw c3 stall", {27'b0, stall_o}, 32'hF);
    step(0, 1, 1, 0, 0);
    chk("mw ack stall", {27'b0, stall_o}, 32'h0);
    step(0, 1, 1, 0, 0);
    chk("req+ack stall", {27'b0, stall_o}, 32'h0);
    step(0, 0, 0, 0, 0);

    // Branch held during memory wait is taken on the release cycle.
    step(0, 1, 0, 1, 32'h0000_0200);
    chk("mwbr c1 redirect", {31'b0, pc_redirect_o}, 32'h0);
    step(0, 1, 0, 1, 32'h0000_0200);
    step(0, 1, 0, 1, 32'h0000_0200);
    chk("mwbr c3 redirect", {31'b0, pc_redirect_o}, 32'h0);
    step(0, 1, 1, 1, 32'h0000_0200);
    chk("mwbr ack stall", {27'b0, stall_o}, 32'h0);
    chk("mwbr ack flush", {27'b0, flush_o}, 32'h3);
    chk("mwbr ack redirect", {31'b0, pc_redirect_o}, 32'h1);
    chk("mwbr ack target", pc_target_o, 32'h200);
    step(0, 0, 0, 0, 0);

    // Watchdog: request cycle plus TMO waiting cycles, then a one-cycle abort.
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= TMO; i++) step(0, 1, 0, 0, 0);
    chk("tmo last stall", {27'b0, stall_o}, 32'hF);
    chk("tmo last abort", {31'b0, mem_abort_o}, 32'h0);
    step(0, 0, 1, 0, 0);
    chk("abort pulse", {31'b0, mem_abort_o}, 32'h1);
    chk("abort flush", {27'b0, flush_o}, 32'h8);
    chk("abort stall", {27'b0, stall_o}, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("post abort", {31'b0, mem_abort_o}, 32'h0);
    chk("post abort stall", {27'b0, stall_o}, 32'h0);

    // Asynchronous reset in the middle of a memory wait.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst stall", {27'b0, stall_o}, 32'h0);
    chk("rst abort", {31'b0, mem_abort_o}, 32'h0);
    chk("rst stall_cycles", stall_cycles_o, 32'h0);
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("rst release abort", {31'b0, mem_abort_o}, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("rst release abort2", {31'b0, mem_abort_o}, 32'h0);

    // Mixed directed traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 60; i++)
      step(i % 3 == 1, i % 6 == 0, (i % 6 == 3) || (i % 11 == 5), i % 5 == 2, 32'h1000 + 32'(i * 4));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
